// File: rtl/ema_pkg.sv
// Shared types and constants for the multi-channel EMA scheduler.
// The filter coefficient is fixed: y = x/4 + 3*y/4.
package ema_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_OUT  = 2'd2
  } ema_state_e;

  localparam int ALPHA_SHIFT = 2;
  localparam int NUM_CH_DEF  = 4;
  localparam int DATA_W_DEF  = 8;

endpackage

// File: rtl/ema_lut_beta.sv
// Beta-term table for the EMA filter: data = floor(3*addr/4).
// Purely combinational so the CALC cycle can consume it directly.
module ema_lut_beta (
  input  logic [7:0]  addr,
  output logic [15:0] data
);

  assign data = (16'(addr) * 16'd3) >> 2;

endmodule

// File: rtl/ema_channel_scheduler.sv
// Round-robin scheduler sharing one EMA datapath between NUM_CH channels.
// One sample is in flight at a time; each channel keeps its own filter state.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | arbitrating; in_ready one-hot to the granted channel
//   CALC    | computing y_new for the registered sample
//   OUT     | presenting result; held until out_ready
module ema_channel_scheduler
  import ema_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  localparam int CH_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     busy
);

  ema_state_e st_q, st_d;

  logic [CH_W-1:0]   last_grant_q;
  logic [CH_W-1:0]   ch_q;
  logic [CH_W-1:0]   out_ch_q;
  logic [CH_W-1:0]   grant_ch;
  logic              grant_found;
  logic              handshake;
  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] y_prev;
  logic [DATA_W-1:0] y_new;
  logic [DATA_W-1:0] beta;
  logic [DATA_W-1:0] ystate_q [NUM_CH];
  logic [NUM_CH-1:0] primed_q;
  logic [7:0]        lut_addr;
  logic [15:0]       lut_data;

  // Search starts one past the last grant; i == NUM_CH wraps back to it.
  always_comb begin
    logic [CH_W-1:0] idx;
    idx         = '0;
    grant_found = 1'b0;
    grant_ch    = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = last_grant_q + CH_W'(i);
      if (!grant_found && in_valid[idx]) begin
        grant_found = 1'b1;
        grant_ch    = idx;
      end
    end
  end

  assign handshake = rst_n && !flush && (st_q == ST_IDLE) && grant_found;

  always_comb begin
    in_ready = '0;
    if (handshake) in_ready[grant_ch] = 1'b1;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE: if (handshake) st_d = ST_CALC;
      ST_CALC: st_d = ST_OUT;
      ST_OUT:  if (out_ready) st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
    if (flush) st_d = ST_IDLE;
  end

  assign y_prev   = ystate_q[ch_q];
  assign lut_addr = 8'(y_prev);

  ema_lut_beta u_lut_beta (
    .addr (lut_addr),
    .data (lut_data)
  );

  assign beta  = lut_data[DATA_W-1:0];
  assign y_new = primed_q[ch_q] ? (x_q >> ALPHA_SHIFT) + beta : x_q;

  generate
    if (DATA_W < 16) begin : g_lut_hi
      logic lut_hi_unused;
      assign lut_hi_unused = ^lut_data[15:DATA_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q         <= ST_IDLE;
      last_grant_q <= CH_W'(NUM_CH - 1);
      ch_q         <= '0;
      x_q          <= '0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      primed_q     <= '0;
      for (int c = 0; c < NUM_CH; c++) ystate_q[c] <= '0;
    end else begin
      st_q <= st_d;
      if (flush) begin
        primed_q <= '0;
        for (int c = 0; c < NUM_CH; c++) ystate_q[c] <= '0;
      end else begin
        if (handshake) begin
          x_q          <= in_data[int'(grant_ch)*DATA_W +: DATA_W];
          ch_q         <= grant_ch;
          last_grant_q <= grant_ch;
        end
        if (st_q == ST_CALC) begin
          ystate_q[ch_q] <= y_new;
          primed_q[ch_q] <= 1'b1;
          out_data_q     <= y_new;
          out_ch_q       <= ch_q;
        end
      end
    end
  end

  assign out_valid = (st_q == ST_OUT);
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign busy      = (st_q != ST_IDLE);

endmodule

// File: tb/tb_ema_channel_scheduler.sv
// Randomized + directed bench for ema_channel_scheduler with a scoreboard.
// The reference model applies the EMA rule per channel at acceptance time.
module tb_ema_channel_scheduler;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_ch;
  logic           busy;

  ema_channel_scheduler #(.NUM_CH(N), .DATA_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: per-channel filter value, primed flag, last grant and
  // how far the one in-flight sample has progressed (0 none, 1 calc, 2 out).
  int m_y [N];
  bit m_pr[N];
  int m_last;
  int m_stage;

  typedef struct { int ch; int val; } exp_t;
  exp_t sb[$];

  int last_val = -1;
  int hs_ch[$];
  int hs_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin m_y[c] = 0; m_pr[c] = 0; end
    m_last  = N - 1;
    m_stage = 0;
    sb.delete();
  endtask

  task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d,
                       input bit ordy, input bit fl, input bit rn);
    int g;
    int x;
    int yn;
    logic [N-1:0] er;
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = ordy; flush = fl; rst_n = rn;
    cyc++;
    #1;
    g  = -1;
    er = '0;
    if (rn && !fl && m_stage == 0)
      for (int i = 1; i <= N; i++) begin
        int c;
        c = (m_last + i) % N;
        if (g < 0 && v[c]) g = c;
      end
    if (g >= 0) er[g] = 1'b1;
    chk("in_ready", in_ready, er);
    chk("busy", busy, m_stage != 0);
    chk("out_valid", out_valid, m_stage == 2);
    for (int i = 0; i < N; i++)
      if (in_ready[i] === 1'b1) begin hs_ch.push_back(i); hs_cyc.push_back(cyc); end
    @(posedge clk);
    if (!rn) model_reset();
    else if (fl) begin
      for (int c = 0; c < N; c++) begin m_y[c] = 0; m_pr[c] = 0; end
      m_stage = 0;
      sb.delete();
    end else begin
      case (m_stage)
        0: if (g >= 0) begin
          x  = int'(d[g*W +: W]);
          yn = m_pr[g] ? (x / 4 + (3 * m_y[g]) / 4) : x;
          m_y[g] = yn; m_pr[g] = 1; m_last = g; m_stage = 1;
          sb.push_back('{g, yn});
        end
        1: m_stage = 2;
        default: if (ordy) m_stage = 0;
      endcase
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (m_stage != 0 && n < 12) begin
      cycle('0, '0, 1'b1, 1'b0, 1'b1);
      n++;
    end
    if (m_stage != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: sample still in flight after %0d cycles", n);
    end
  endtask

  task automatic send(input int ch, input int x);
    logic [N*W-1:0] d;
    logic [N-1:0] v;
    d = '0; v = '0;
    d[ch*W +: W] = W'(x);
    v[ch] = 1'b1;
    cycle(v, d, 1'b1, 1'b0, 1'b1);
    drain();
  endtask

  // Monitor: pops the scoreboard on each output handshake and checks that a
  // stalled result stays frozen.
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_data;
  logic [1:0]   prev_ch;
  always begin
    exp_t e;
    @(negedge clk);
    #3;
    if (prev_hold) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_data", out_data, prev_data);
      chk("hold_ch", out_ch, prev_ch);
    end
    if (rst_n && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got ch %0d data %0d expected nothing", out_ch, out_data);
      end else begin
        e = sb.pop_front();
        chk("out_ch", out_ch, e.ch);
        chk("out_data", out_data, e.val);
        last_val = int'(out_data);
      end
    end
    prev_hold = rst_n && !flush && out_valid && !out_ready;
    prev_data = out_data;
    prev_ch   = out_ch;
  end

  initial begin
    logic [N*W-1:0] rd;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; in_valid = '0; in_data = '0;
    model_reset();

    cycle('0, '0, 1'b1, 1'b0, 1'b0);
    cycle('0, '0, 1'b1, 1'b0, 1'b0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_ch", out_ch, 0);

    // priming
    send(0, 100); chk("prime_first", last_val, 100);
    send(0, 200); chk("prime_second", last_val, 125);

    // round robin from reset with all channels requesting
    cycle('0, '0, 1'b1, 1'b0, 1'b0);
    hs_ch.delete(); hs_cyc.delete();
    for (int i = 0; i < 15; i++) begin
      rd = {$urandom, $urandom};
      cycle('1, rd, 1'b1, 1'b0, 1'b1);
    end
    if (hs_ch.size() < 5) begin
      checks++; errors++;
      $display("FAIL rr_count: got %0d handshakes expected at least 5", hs_ch.size());
    end else begin
      for (int i = 0; i < 5; i++) chk("rr_order", hs_ch[i], i % N);
      for (int i = 1; i < 5; i++) chk("rr_spacing", hs_cyc[i] - hs_cyc[i-1], 3);
    end
    drain();

    // backpressure: others keep requesting while the result is stalled
    rd = {$urandom, $urandom};
    cycle(4'b0010, rd, 1'b1, 1'b0, 1'b1);
    cycle('1, rd, 1'b1, 1'b0, 1'b1);
    repeat (5) cycle('1, rd, 1'b0, 1'b0, 1'b1);
    drain();

    // flush during OUT
    cycle('0, '0, 1'b1, 1'b0, 1'b0);
    send(0, 60);
    cycle(4'b0001, 32'd50, 1'b1, 1'b0, 1'b1);
    cycle('0, '0, 1'b0, 1'b0, 1'b1);
    cycle('0, '0, 1'b0, 1'b0, 1'b1);
    cycle('0, '0, 1'b0, 1'b1, 1'b1);
    cycle('0, '0, 1'b1, 1'b0, 1'b1);
    send(0, 40); chk("flush_unprimed", last_val, 40);

    // max value on ch2, ch1 untouched
    send(1, 80);  chk("ch1_first", last_val, 80);
    send(2, 255); chk("ch2_first", last_val, 255);
    send(2, 255); chk("ch2_max", last_val, 254);
    send(1, 80);  chk("ch1_after", last_val, 80);

    // reset while in CALC
    cycle(4'b0001, 32'd77, 1'b1, 1'b0, 1'b1);
    cycle('0, '0, 1'b1, 1'b0, 1'b0);
    #2;
    chk("midreset_valid", out_valid, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_data", out_data, 0);
    chk("midreset_ch", out_ch, 0);
    send(0, 10); chk("after_reset", last_val, 10);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rd = {$urandom, $urandom};
      cycle(N'($urandom_range(0, 15)), rd, $urandom_range(0, 9) < 7,
            $urandom_range(0, 49) == 0, !($urandom_range(0, 99) == 0));
    end
    drain();
    cycle('0, '0, 1'b1, 1'b0, 1'b1);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
